// File: rtl/led_pkg.sv
// led_pkg: shared states and constants for the LED strip link receiver.
// Optional watchdog in the receiver is enabled with `LED_RECV_TIMEOUT_EN.
package led_pkg;

   typedef enum logic [1:0] {
      IDLE,
      SYNC,
      DATA
   } recv_state_t;

   localparam logic [31:0] LED_START_FRAME = 32'h0000_0000;
   localparam logic [31:0] LED_END_FRAME   = 32'hFFFF_FFFF;
   localparam logic [2:0]  LED_HDR         = 3'b111;

   localparam logic [1:0] ERR_HDR = 2'd0;
   localparam logic [1:0] ERR_END = 2'd1;
   localparam logic [1:0] ERR_OVF = 2'd2;
   localparam logic [1:0] ERR_TMO = 2'd3;

endpackage

// File: rtl/led_sync_edge.sv
// led_sync_edge: two-flop synchronisers for cki/sdi and cki rise detect.
// Optional receiver watchdog is enabled with `LED_RECV_TIMEOUT_EN.
module led_sync_edge (
   input  logic clk,
   input  logic rstn,
   input  logic cki,
   input  logic sdi,
   output logic sdi_s,
   output logic cki_rise
);

   logic [2:0] cki_q;
   logic [1:0] sdi_q;

   // cki idles high, so its flops come out of reset high: no false rise.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         cki_q <= 3'b111;
         sdi_q <= 2'b00;
      end else begin
         cki_q <= {cki_q[1:0], cki};
         sdi_q <= {sdi_q[0], sdi};
      end
   end

   assign sdi_s    = sdi_q[1];
   assign cki_rise = cki_q[1] & ~cki_q[2];

endmodule

// File: rtl/led_recv.sv
// led_recv: decodes start / LED_NUM LED / end frames into FIFO writes.
// Define `LED_RECV_TIMEOUT_EN to abort stalled packets after TIMEOUT_CNT clk.
module led_recv #(
   parameter int LED_NUM     = 4,
   parameter int TIMEOUT_CNT = 64
) (
   input  logic        clk,
   input  logic        rstn,
   input  logic        cki,
   input  logic        sdi,
   input  logic        fifo_full,
   output logic        wr,
   output logic [23:0] wdata,
   output logic [4:0]  bright,
   output logic        frame_done,
   output logic        err,
   output logic [1:0]  err_code
);
   import led_pkg::*;

   localparam int IW = $clog2(LED_NUM + 1);

   recv_state_t state, state_nx;

   logic          sdi_s;
   logic          cki_rise;
   logic [31:0]   sh;
   logic [31:0]   sh_nx;
   logic [5:0]    zero_cnt;
   logic [4:0]    bit_cnt;
   logic [IW-1:0] led_idx;
   logic          frame_end;
   logic          is_end;
   logic          tmo;
   logic          ovf;

   logic          wr_pend, wr_nx;
   logic          done_q, done_nx;
   logic          err_q, err_nx;
   logic [1:0]    code_q, code_nx;
   logic [23:0]   wdata_q;
   logic [4:0]    bright_q;

   led_sync_edge u_sync (
      .clk      (clk),
      .rstn     (rstn),
      .cki      (cki),
      .sdi      (sdi),
      .sdi_s    (sdi_s),
      .cki_rise (cki_rise)
   );

   assign sh_nx     = {sh[30:0], sdi_s};
   assign frame_end = (state == DATA) && cki_rise && (bit_cnt == 5'd31);
   assign is_end    = (led_idx == IW'(LED_NUM));

`ifdef LED_RECV_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT_CNT) + 1;

   logic [TW-1:0] idle_cnt;

   assign tmo = (state != IDLE) && !cki_rise &&
                (idle_cnt == TW'(TIMEOUT_CNT - 1));

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn)
         idle_cnt <= '0;
      else if (state == IDLE || cki_rise)
         idle_cnt <= '0;
      else
         idle_cnt <= idle_cnt + 1'b1;
   end
`else
   logic [31:0] unused_tmo;

   assign unused_tmo = TIMEOUT_CNT;
   assign tmo        = 1'b0;
`endif

   always_comb begin
      state_nx = state;
      wr_nx    = 1'b0;
      done_nx  = 1'b0;
      err_nx   = 1'b0;
      code_nx  = ERR_HDR;
      unique case (state)
         IDLE: if (zero_cnt == 6'd32) state_nx = SYNC;
         SYNC: if (cki_rise && sdi_s) state_nx = DATA;
         DATA: begin
            if (frame_end && !is_end) begin
               if (sh_nx[31:29] == LED_HDR) begin
                  wr_nx = 1'b1;
               end else begin
                  err_nx  = 1'b1;
                  code_nx = ERR_HDR;
               end
            end
            if (frame_end && is_end) begin
               state_nx = IDLE;
               if (sh_nx == LED_END_FRAME) begin
                  done_nx = 1'b1;
               end else begin
                  err_nx  = 1'b1;
                  code_nx = ERR_END;
               end
            end
         end
         default: state_nx = IDLE;
      endcase
      if (tmo) begin
         state_nx = IDLE;
         err_nx   = 1'b1;
         code_nx  = ERR_TMO;
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn)
         state <= IDLE;
      else
         state <= state_nx;
   end

   // zero_cnt only runs while parked in IDLE, so it restarts on return.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         sh       <= '0;
         zero_cnt <= '0;
         bit_cnt  <= '0;
         led_idx  <= '0;
      end else begin
         if (cki_rise)
            sh <= sh_nx;
         if (state != IDLE || state_nx != IDLE)
            zero_cnt <= '0;
         else if (cki_rise && sdi_s)
            zero_cnt <= '0;
         else if (cki_rise && zero_cnt != 6'd32)
            zero_cnt <= zero_cnt + 6'd1;
         if (state_nx == IDLE) begin
            bit_cnt <= '0;
            led_idx <= '0;
         end else if (state == SYNC && cki_rise && sdi_s) begin
            bit_cnt <= 5'd1;
            led_idx <= '0;
         end else if (state == DATA && cki_rise) begin
            bit_cnt <= bit_cnt + 5'd1;
            if (frame_end)
               led_idx <= led_idx + 1'b1;
         end
      end
   end

   assign ovf = wr_pend & fifo_full;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         wr_pend  <= 1'b0;
         done_q   <= 1'b0;
         err_q    <= 1'b0;
         code_q   <= ERR_HDR;
         wdata_q  <= '0;
         bright_q <= '0;
      end else begin
         wr_pend <= wr_nx;
         done_q  <= done_nx;
         err_q   <= err_nx;
         if (err_nx)
            code_q <= code_nx;
         else if (ovf)
            code_q <= ERR_OVF;
         if (wr_nx) begin
            wdata_q  <= sh_nx[23:0];
            bright_q <= sh_nx[28:24];
         end
      end
   end

   // Overflow is judged in the write cycle itself and replaces the write.
   assign wr         = wr_pend & ~fifo_full;
   assign err        = err_q | ovf;
   assign err_code   = ovf ? ERR_OVF : code_q;
   assign frame_done = done_q;
   assign wdata      = wdata_q;
   assign bright     = bright_q;

endmodule

// File: tb/tb_led_recv.sv
// tb_led_recv: drives serial LED packets and checks decoded writes/errors.
// Timeout scenario runs only when `LED_RECV_TIMEOUT_EN is defined.
`timescale 1ns/1ps
module tb_led_recv;

   localparam int LED_NUM = 4;

   logic        clk = 1'b0;
   logic        rstn;
   logic        cki;
   logic        sdi;
   logic        fifo_full;
   logic        wr;
   logic [23:0] wdata;
   logic [4:0]  bright;
   logic        frame_done;
   logic        err;
   logic [1:0]  err_code;

   int n_tests = 0;
   int n_fail  = 0;

   logic [28:0] got_wr[$];
   logic [28:0] exp_wr[$];
   logic [1:0]  got_err[$];
   logic [1:0]  exp_err[$];
   int          got_done;
   int          exp_done;
   int          both_cnt = 0;
   bit          wr_ok;
   bit          err_ok;

   logic [31:0] pkt_led [LED_NUM];
   logic        pkt_full [LED_NUM];
   logic [31:0] pkt_end;
   int          pkt_pad;

   always #3 clk = ~clk;

   led_recv #(.LED_NUM(LED_NUM), .TIMEOUT_CNT(64)) dut (
      .clk        (clk),
      .rstn       (rstn),
      .cki        (cki),
      .sdi        (sdi),
      .fifo_full  (fifo_full),
      .wr         (wr),
      .wdata      (wdata),
      .bright     (bright),
      .frame_done (frame_done),
      .err        (err),
      .err_code   (err_code)
   );

   always @(negedge clk) begin
      if (wr) got_wr.push_back({bright, wdata});
      if (err) got_err.push_back(err_code);
      if (frame_done) got_done++;
      if (wr && err) both_cnt++;
   end

   task automatic send_bit(input logic b);
      @(negedge clk);
      cki = 1'b0;
      sdi = b;
      repeat (5) @(negedge clk);
      cki = 1'b1;
      repeat (4) @(negedge clk);
   endtask

   task automatic send_bits(input logic [31:0] w, input int n);
      for (int i = 31; i > 31 - n; i--) send_bit(w[i]);
   endtask

   task automatic clear_obs();
      got_wr.delete();
      exp_wr.delete();
      got_err.delete();
      exp_err.delete();
      got_done = 0;
      exp_done = 0;
   endtask

   task automatic set_clean();
      pkt_led[0] = 32'hFF11_2233;
      pkt_led[1] = 32'hFF44_5566;
      pkt_led[2] = 32'hE000_0000;
      pkt_led[3] = 32'hFFFF_FFFF;
      for (int i = 0; i < LED_NUM; i++) pkt_full[i] = 1'b0;
      pkt_end = 32'hFFFF_FFFF;
      pkt_pad = 0;
   endtask

   // Reference: what each frame position should produce.
   task automatic model_packet();
      for (int i = 0; i < LED_NUM; i++) begin
         if (pkt_led[i][31:29] != 3'b111) exp_err.push_back(2'd0);
         else if (pkt_full[i]) exp_err.push_back(2'd2);
         else exp_wr.push_back(pkt_led[i][28:0]);
      end
      if (pkt_end == 32'hFFFF_FFFF) exp_done++;
      else exp_err.push_back(2'd1);
   endtask

   task automatic score();
      wr_ok = (got_wr.size() == exp_wr.size());
      foreach (exp_wr[i])
         if (wr_ok && got_wr[i] !== exp_wr[i]) wr_ok = 1'b0;
      err_ok = (got_err.size() == exp_err.size());
      foreach (exp_err[i])
         if (err_ok && got_err[i] !== exp_err[i]) err_ok = 1'b0;
   endtask

   task automatic run_packet();
      model_packet();
      send_bits(32'h0, 32);
      for (int i = 0; i < pkt_pad; i++) send_bit(1'b0);
      for (int i = 0; i < LED_NUM; i++) begin
         fifo_full = pkt_full[i];
         send_bits(pkt_led[i], 32);
      end
      fifo_full = 1'b0;
      send_bits(pkt_end, 32);
      repeat (20) @(negedge clk);
      score();
   endtask

   task automatic test_reset();
      rstn = 1'b0;
      repeat (3) @(negedge clk);
      n_tests++;
      if ({wr, wdata, bright, frame_done, err, err_code} !== 34'd0) begin
         n_fail++;
         $display("FAIL reset_outputs: got wr=%b wdata=%h bright=%h done=%b err=%b code=%0d, required all 0",
                  wr, wdata, bright, frame_done, err, err_code);
      end
      rstn = 1'b1;
      repeat (5) @(negedge clk);
      n_tests++;
      if ({wr, frame_done, err} !== 3'b000) begin
         n_fail++;
         $display("FAIL reset_release: got wr=%b done=%b err=%b, required 000",
                  wr, frame_done, err);
      end
   endtask

   task automatic test_basic(input int pad, input string tag);
      set_clean();
      pkt_pad = pad;
      clear_obs();
      run_packet();
      n_tests++;
      if (wr_ok !== 1'b1 || got_wr.size() != 4 ||
          got_wr[0] !== {5'h1F, 24'h112233} ||
          got_wr[2] !== {5'h00, 24'h000000} ||
          got_wr[3] !== {5'h1F, 24'hFFFFFF}) begin
         n_fail++;
         $display("FAIL %s_wr: got %0d writes (first %h), required 4 (first %h)",
                  tag, got_wr.size(), got_wr[0], {5'h1F, 24'h112233});
      end
      n_tests++;
      if (got_err.size() !== 0) begin
         n_fail++;
         $display("FAIL %s_err: got %0d errors, required 0", tag, got_err.size());
      end
      n_tests++;
      if (got_done !== 1) begin
         n_fail++;
         $display("FAIL %s_done: got %0d, required 1", tag, got_done);
      end
   endtask

   task automatic test_bad_header();
      set_clean();
      pkt_led[2] = 32'h5F00_0001;
      clear_obs();
      run_packet();
      n_tests++;
      if (wr_ok !== 1'b1 || got_wr.size() != 3) begin
         n_fail++;
         $display("FAIL hdr_wr: got %0d writes, required 3", got_wr.size());
      end
      n_tests++;
      if (err_ok !== 1'b1 || got_err.size() != 1 || got_err[0] !== 2'd0) begin
         n_fail++;
         $display("FAIL hdr_err: got %0d errors (code %0d), required 1 (code 0)",
                  got_err.size(), got_err[0]);
      end
      n_tests++;
      if (got_done !== 1) begin
         n_fail++;
         $display("FAIL hdr_done: got %0d, required 1", got_done);
      end
   endtask

   task automatic test_bad_end();
      set_clean();
      pkt_end = 32'hFFFF_FFFE;
      clear_obs();
      run_packet();
      n_tests++;
      if (err_ok !== 1'b1 || got_err.size() != 1 || got_err[0] !== 2'd1) begin
         n_fail++;
         $display("FAIL end_err: got %0d errors (code %0d), required 1 (code 1)",
                  got_err.size(), got_err[0]);
      end
      n_tests++;
      if (got_done !== 0 || wr_ok !== 1'b1) begin
         n_fail++;
         $display("FAIL end_done: got done=%0d writes=%0d, required done=0 writes=4",
                  got_done, got_wr.size());
      end
      test_basic(0, "after_end");
   endtask

   task automatic test_overflow();
      set_clean();
      pkt_full[0] = 1'b1;
      clear_obs();
      run_packet();
      n_tests++;
      if (wr_ok !== 1'b1 || got_wr.size() != 3 ||
          got_wr[0] !== {5'h1F, 24'h445566}) begin
         n_fail++;
         $display("FAIL ovf_wr: got %0d writes (first %h), required 3 (first %h)",
                  got_wr.size(), got_wr[0], {5'h1F, 24'h445566});
      end
      n_tests++;
      if (err_ok !== 1'b1 || got_err.size() != 1 || got_err[0] !== 2'd2) begin
         n_fail++;
         $display("FAIL ovf_err: got %0d errors (code %0d), required 1 (code 2)",
                  got_err.size(), got_err[0]);
      end
   endtask

   task automatic test_random(input int n);
      logic [2:0] hdr;
      int         lo;
      for (int p = 0; p < n; p++) begin
         for (int i = 0; i < LED_NUM; i++) begin
            lo = (i == 0) ? 4 : 0;
            hdr = ($urandom_range(0, 3) != 0) ? 3'b111 : 3'($urandom_range(lo, 6));
            pkt_led[i]  = {hdr, 29'($urandom)};
            pkt_full[i] = ($urandom_range(0, 3) == 0);
         end
         pkt_end = ($urandom_range(0, 3) != 0) ? 32'hFFFF_FFFF :
                   ~(32'h1 << $urandom_range(0, 31));
         pkt_pad = $urandom_range(0, 12);
         clear_obs();
         run_packet();
         n_tests++;
         if (wr_ok !== 1'b1) begin
            n_fail++;
            $display("FAIL rand%0d_wr: got %0d writes, required %0d as modelled",
                     p, got_wr.size(), exp_wr.size());
         end
         n_tests++;
         if (err_ok !== 1'b1) begin
            n_fail++;
            $display("FAIL rand%0d_err: got %0d errors, required %0d as modelled",
                     p, got_err.size(), exp_err.size());
         end
         n_tests++;
         if (got_done !== exp_done) begin
            n_fail++;
            $display("FAIL rand%0d_done: got %0d, required %0d", p, got_done, exp_done);
         end
      end
   endtask

   task automatic test_reset_mid();
      clear_obs();
      send_bits(32'h0, 32);
      send_bits(32'hFF11_2233, 10);
      rstn = 1'b0;
      repeat (2) @(negedge clk);
      rstn = 1'b1;
      repeat (40) @(negedge clk);
      n_tests++;
      if (got_wr.size() !== 0 || got_err.size() !== 0) begin
         n_fail++;
         $display("FAIL rst_mid: got %0d writes %0d errors, required 0 and 0",
                  got_wr.size(), got_err.size());
      end
      test_basic(0, "after_rst");
   endtask

`ifdef LED_RECV_TIMEOUT_EN
   task automatic test_timeout();
      clear_obs();
      exp_wr.push_back(29'h1F11_2233);
      exp_err.push_back(2'd3);
      send_bits(32'h0, 32);
      send_bits(32'hFF11_2233, 32);
      send_bits(32'hFF44_5566, 10);
      repeat (100) @(negedge clk);
      score();
      n_tests++;
      if (wr_ok !== 1'b1 || err_ok !== 1'b1) begin
         n_fail++;
         $display("FAIL timeout: got %0d writes %0d errors (code %0d), required 1 write 1 error (code 3)",
                  got_wr.size(), got_err.size(), got_err[0]);
      end
      test_basic(0, "after_tmo");
   endtask
`endif

   initial begin
      rstn      = 1'b0;
      cki       = 1'b1;
      sdi       = 1'b0;
      fifo_full = 1'b0;
      test_reset();
      test_basic(0, "basic");
      test_basic(8, "pad40");
      test_bad_header();
      test_bad_end();
      test_overflow();
      test_random(6);
`ifdef LED_RECV_TIMEOUT_EN
      test_timeout();
`endif
      test_reset_mid();
      n_tests++;
      if (both_cnt !== 0) begin
         n_fail++;
         $display("FAIL wr_err_overlap: got %0d cycles, required 0", both_cnt);
      end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
